transmissor_oled: RTL and testbench

Downstream stage of the image controller. On request, it captures the 1024-byte frame from `imagem` (128×64 monochrome, page-ordered) and streams it to the SSD1306-class OLED over a write-only SPI link (mode 0). Each frame starts with a fixed address-window command header, followed by the pixel data. It is the only block that drives the display pins.

---
 rtl/transmissor_oled.sv | 172 +++++++++++++++++
 tb/tb_transmissor_oled.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_oled.sv
// OLED transmitter: captures a 128x64 page-ordered frame and streams it over write-only
// SPI mode 0, preceded by a fixed column/page address-window command header.
module transmissor_oled #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [8191:0] imagem,
   input  logic          iniciar,
   output logic          ocupado,
   output logic          quadro_pronto,
   output logic          oled_sclk,
   output logic          oled_mosi,
   output logic          oled_dc,
   output logic          oled_cs_n
);

   localparam int unsigned N_IMG   = 1024;
   localparam int unsigned IMG_W   = N_IMG * 8;
   localparam int unsigned N_CMD   = 6;
   localparam int unsigned N_BYTES = N_CMD + N_IMG;
   localparam int unsigned BYTE_W  = $clog2(N_BYTES);
   localparam int unsigned IDX_W   = $clog2(N_IMG);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      CMD    = 2'd1,
      DADOS  = 2'd2,
      FIM    = 2'd3
   } estado_t;

   // Address window: columns 0..127, pages 0..7
   function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
      logic [7:0] val;
      case (idx)
         3'd0:    val = 8'h21;
         3'd1:    val = 8'h00;
         3'd2:    val = 8'h7F;
         3'd3:    val = 8'h22;
         3'd4:    val = 8'h00;
         3'd5:    val = 8'h07;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

   localparam logic [7:0] CMD0 = 8'h21;

   estado_t           state_q;
   logic [IMG_W-1:0]  buf_q;
   logic [BYTE_W-1:0] byte_q;
   logic [2:0]        bit_q;
   logic [DIV_W-1:0]  div_q;
   logic              ocupado_q;
   logic              pronto_q;
   logic              sclk_q;
   logic              mosi_q;
   logic              dc_q;
   logic              cs_n_q;

   logic [BYTE_W-1:0] byte_d;
   logic [2:0]        bit_d;
   logic [IDX_W-1:0]  dado_idx_d;
   logic [7:0]        byte_val_d;
   logic              mosi_d;
   logic              dc_d;
   logic              fim_bit_c;
   logic              ultimo_c;
   logic              fim_div_c;
   logic              aceita_c;

   // Position and value of the bit that follows the one currently on the line
   always_comb begin
      fim_bit_c  = (bit_q == 3'd0);
      byte_d     = fim_bit_c ? byte_q + BYTE_W'(1) : byte_q;
      bit_d      = fim_bit_c ? 3'd7 : bit_q - 3'd1;
      dado_idx_d = IDX_W'(byte_d - BYTE_W'(N_CMD));
      if (byte_d < BYTE_W'(N_CMD)) begin
         byte_val_d = cmd_byte(3'(byte_d));
      end else begin
         byte_val_d = buf_q[{dado_idx_d, 3'b000} +: 8];
      end
      mosi_d    = byte_val_d[bit_d];
      dc_d      = (byte_d >= BYTE_W'(N_CMD));
      ultimo_c  = fim_bit_c && (byte_q == BYTE_W'(N_BYTES - 1));
      fim_div_c = (div_q == DIV_W'(CLK_DIV - 1));
      aceita_c  = iniciar && ((state_q == OCIOSO) || (state_q == FIM));
   end

   // Frame buffer: loaded only when a request is accepted, so the frame in flight is isolated
   always_ff @(posedge clk) begin
      if (!rst && aceita_c) begin
         buf_q <= imagem;
      end
   end

   // Transmit FSM with registered pin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= OCIOSO;
         byte_q    <= '0;
         bit_q     <= 3'd7;
         div_q     <= '0;
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         dc_q      <= 1'b0;
         cs_n_q    <= 1'b1;
      end else begin
         pronto_q <= 1'b0;
         case (state_q)
            OCIOSO, FIM: begin
               state_q   <= OCIOSO;
               ocupado_q <= 1'b0;
               sclk_q    <= 1'b0;
               mosi_q    <= 1'b0;
               dc_q      <= 1'b0;
               cs_n_q    <= 1'b1;
               if (iniciar) begin
                  state_q   <= CMD;
                  byte_q    <= '0;
                  bit_q     <= 3'd7;
                  div_q     <= '0;
                  ocupado_q <= 1'b1;
                  mosi_q    <= CMD0[7];
                  cs_n_q    <= 1'b0;
               end
            end
            CMD, DADOS: begin
               if (!fim_div_c) begin
                  div_q <= div_q + DIV_W'(1);
               end else begin
                  div_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else if (ultimo_c) begin
                     // Last high phase done: close the frame
                     state_q   <= FIM;
                     sclk_q    <= 1'b0;
                     mosi_q    <= 1'b0;
                     dc_q      <= 1'b0;
                     cs_n_q    <= 1'b1;
                     ocupado_q <= 1'b0;
                     pronto_q  <= 1'b1;
                  end else begin
                     // New low phase: only point where MOSI/DC may change
                     sclk_q <= 1'b0;
                     byte_q <= byte_d;
                     bit_q  <= bit_d;
                     mosi_q <= mosi_d;
                     dc_q   <= dc_d;
                     if (dc_d) begin
                        state_q <= DADOS;
                     end
                  end
               end
            end
            default: state_q <= OCIOSO;
         endcase
      end
   end

   assign ocupado       = ocupado_q;
   assign quadro_pronto = pronto_q;
   assign oled_sclk     = sclk_q;
   assign oled_mosi     = mosi_q;
   assign oled_dc       = dc_q;
   assign oled_cs_n     = cs_n_q;

endmodule

// File: tb/tb_transmissor_oled.sv
// Bench for transmissor_oled: one instance at CLK_DIV=1, one at CLK_DIV=4, with an SPI
// mode-0 monitor decoding bytes and checking phase lengths and data stability.
module tb_transmissor_oled;

   localparam int L1 = 1030 * 8 * 2 * 1;
   localparam int L4 = 65920;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst0, rst1, ini0, ini1;
   logic [8191:0] img0, img1;
   wire  [1:0]    ocup, qp, sclk, mosi, dc, csn;

   transmissor_oled #(.CLK_DIV(1)) u_div1 (
      .clk(clk), .rst(rst0), .imagem(img0), .iniciar(ini0),
      .ocupado(ocup[0]), .quadro_pronto(qp[0]), .oled_sclk(sclk[0]),
      .oled_mosi(mosi[0]), .oled_dc(dc[0]), .oled_cs_n(csn[0]));

   transmissor_oled #(.CLK_DIV(4)) u_div4 (
      .clk(clk), .rst(rst1), .imagem(img1), .iniciar(ini1),
      .ocupado(ocup[1]), .quadro_pronto(qp[1]), .oled_sclk(sclk[1]),
      .oled_mosi(mosi[1]), .oled_dc(dc[1]), .oled_cs_n(csn[1]));

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [8:0] mbuf [2][8192];
   int   mcnt[2]        = '{0, 0};
   logic [7:0] shr[2];
   int   bitc[2]        = '{0, 0};
   int   rise_cnt[2]    = '{0, 0};
   int   stab_err[2]    = '{0, 0};
   int   phase_err[2]   = '{0, 0};
   int   run[2]         = '{0, 0};
   int   hi_run[2]      = '{0, 0};
   int   last_hi_run[2] = '{0, 0};
   int   qp_cnt[2]      = '{0, 0};
   int   csfall_cyc[2]  = '{0, 0};
   int   div_of[2]      = '{1, 4};
   logic [1:0] p_sclk = 2'b00, p_mosi = 2'b00, p_dc = 2'b00, p_csn = 2'b11;

   always @(posedge clk) cyc <= cyc + 1;

   // SPI monitor, sampled on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (sclk[k] === 1'b1 && p_sclk[k] === 1'b0) rise_cnt[k]++;
         if (csn[k] !== 1'b0) begin
            bitc[k] = 0;
         end else if (sclk[k] === 1'b1 && p_sclk[k] === 1'b0) begin
            shr[k] = {shr[k][6:0], mosi[k]};
            bitc[k]++;
            if (bitc[k] == 8) begin
               if (mcnt[k] < 8192) mbuf[k][mcnt[k]] = {dc[k], shr[k]};
               mcnt[k]++;
               bitc[k] = 0;
            end
         end
         if (csn[k] === 1'b0 && p_csn[k] === 1'b0 && !(p_sclk[k] === 1'b1 && sclk[k] === 1'b0)
             && (mosi[k] !== p_mosi[k] || dc[k] !== p_dc[k]))
            stab_err[k]++;
         if (csn[k] === 1'b0 && p_csn[k] === 1'b0) begin
            if (sclk[k] === p_sclk[k]) run[k]++;
            else begin
               if (run[k] != div_of[k]) phase_err[k]++;
               run[k] = 1;
            end
         end else if (csn[k] === 1'b0) begin
            run[k] = 1;
            csfall_cyc[k] = cyc;
            last_hi_run[k] = hi_run[k];
         end else if (p_csn[k] === 1'b0) begin
            if (run[k] != div_of[k]) phase_err[k]++;
         end
         if (csn[k] === 1'b1) hi_run[k]++;
         else hi_run[k] = 0;
         if (qp[k] === 1'b1) qp_cnt[k]++;
         p_sclk[k] = sclk[k];
         p_mosi[k] = mosi[k];
         p_dc[k]   = dc[k];
         p_csn[k]  = csn[k];
      end
   end

   function automatic logic [8:0] exp_byte(input logic [8191:0] im, input int i);
      logic [8:0] v;
      case (i)
         0: v = 9'h021;
         1: v = 9'h000;
         2: v = 9'h07F;
         3: v = 9'h022;
         4: v = 9'h000;
         5: v = 9'h007;
         default: v = {1'b1, im[(i - 6) * 8 +: 8]};
      endcase
      return v;
   endfunction

   function automatic int stream_errs(input int k, input int base, input logic [8191:0] im);
      int e = 0;
      for (int i = 0; i < 1030; i++)
         if (mbuf[k][base + i] !== exp_byte(im, i)) e++;
      return e;
   endfunction

   task automatic wait_qp(input int k, input int budget, output bit ok, output int at);
      int c = 0;
      ok = 1'b0;
      at = 0;
      while (!ok && c < budget) begin
         @(posedge clk); #1;
         c++;
         if (qp[k] === 1'b1) begin
            ok = 1'b1;
            at = cyc;
         end
      end
   endtask

   task automatic test_reset();
      int r0 = rise_cnt[0];
      int r1 = rise_cnt[1];
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ini0 = ~ini0;
         ini1 = ~ini1;
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({ocup[k], qp[k], sclk[k], mosi[k], dc[k], csn[k]} !== 6'b000001) begin
               n_fail++;
               $display("FAIL reset_outputs[%0d] cycle %0d: got %b want 000001", k, c,
                        {ocup[k], qp[k], sclk[k], mosi[k], dc[k], csn[k]});
            end
         end
      end
      n_cmp++;
      if ((rise_cnt[0] - r0) !== 0 || (rise_cnt[1] - r1) !== 0) begin
         n_fail++;
         $display("FAIL reset_sclk_edges: got %0d/%0d want 0/0", rise_cnt[0] - r0, rise_cnt[1] - r1);
      end
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0; ini0 = 1'b0; ini1 = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [8191:0] orig = '0;
      int base, q0, at, e;
      bit ok;
      orig[7:0] = 8'hA5;
      orig[15:8] = 8'hFF;
      orig[1023 * 8 +: 8] = 8'h3C;
      img0 = orig;
      base = mcnt[0];
      q0 = qp_cnt[0];
      @(negedge clk); ini0 = 1'b1;
      @(posedge clk); #1; ini0 = 1'b0;
      n_cmp++;
      if ({ocup[0], csn[0], dc[0], sclk[0], mosi[0], qp[0]} !== 6'b100000) begin
         n_fail++;
         $display("FAIL single_t1_outputs: got %b want 100000",
                  {ocup[0], csn[0], dc[0], sclk[0], mosi[0], qp[0]});
      end
      // Mid-frame: new image content and a request that must be ignored
      repeat (8000) @(negedge clk);
      img0 = '1;
      ini0 = 1'b1;
      @(negedge clk); ini0 = 1'b0;
      wait_qp(0, 9000, ok, at);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got no pulse want pulse"); end
      n_cmp++;
      if (at - csfall_cyc[0] !== L1) begin
         n_fail++;
         $display("FAIL single_length: got %0d want %0d", at - csfall_cyc[0], L1);
      end
      n_cmp++;
      if (mcnt[0] - base !== 1030) begin
         n_fail++;
         $display("FAIL single_byte_count: got %0d want 1030", mcnt[0] - base);
      end
      n_cmp++;
      if (mbuf[0][base + 5] !== 9'h007 || mbuf[0][base + 6] !== 9'h1A5) begin
         n_fail++;
         $display("FAIL single_cmd_to_data: got %h %h want 007 1a5", mbuf[0][base + 5], mbuf[0][base + 6]);
      end
      n_cmp++;
      if (mbuf[0][base + 7] !== 9'h1FF || mbuf[0][base + 1029] !== 9'h13C) begin
         n_fail++;
         $display("FAIL single_data_bytes: got %h %h want 1ff 13c", mbuf[0][base + 7], mbuf[0][base + 1029]);
      end
      e = stream_errs(0, base, orig);
      n_cmp++;
      if (e !== 0) begin n_fail++; $display("FAIL single_stream: got %0d bad bytes want 0", e); end
      repeat (40) @(negedge clk);
      n_cmp++;
      if (qp_cnt[0] - q0 !== 1 || ocup[0] !== 1'b0 || csn[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_one_frame: got pulses=%0d ocupado=%b cs_n=%b want 1 0 1",
                  qp_cnt[0] - q0, ocup[0], csn[0]);
      end
   endtask

   task automatic test_reset_mid(input logic [8191:0] pat);
      int base, q0, at, e, c;
      bit ok;
      img0 = pat;
      base = mcnt[0];
      @(negedge clk); ini0 = 1'b1;
      @(negedge clk); ini0 = 1'b0;
      c = 0;
      while (mcnt[0] - base < 506 && c < 10000) begin @(negedge clk); c++; end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (mcnt[0] - base !== 506) begin
         n_fail++;
         $display("FAIL rstmid_position: got %0d bytes want 506", mcnt[0] - base);
      end
      q0 = qp_cnt[0];
      rst0 = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({csn[0], sclk[0], ocup[0], qp[0]} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %b want 1000", {csn[0], sclk[0], ocup[0], qp[0]});
      end
      @(negedge clk); rst0 = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (qp_cnt[0] !== q0 || csn[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_no_pulse: got pulses=%0d cs_n=%b want 0 1", qp_cnt[0] - q0, csn[0]);
      end
      base = mcnt[0];
      @(negedge clk); ini0 = 1'b1;
      @(negedge clk); ini0 = 1'b0;
      wait_qp(0, L1 + 100, ok, at);
      n_cmp++;
      if (ok !== 1'b1 || at - csfall_cyc[0] !== L1) begin
         n_fail++;
         $display("FAIL rstmid_refire_length: got ok=%b len=%0d want 1 %0d", ok, at - csfall_cyc[0], L1);
      end
      e = stream_errs(0, base, pat);
      n_cmp++;
      if (mcnt[0] - base !== 1030 || e !== 0) begin
         n_fail++;
         $display("FAIL rstmid_refire_stream: got %0d bytes %0d bad want 1030 0", mcnt[0] - base, e);
      end
   endtask

   task automatic test_back_to_back(input logic [8191:0] pat);
      int base, at1, at2, e1, e2;
      bit ok1, ok2;
      img0 = pat;
      base = mcnt[0];
      @(negedge clk); ini0 = 1'b1;
      wait_qp(0, L1 + 100, ok1, at1);
      wait_qp(0, L1 + 100, ok2, at2);
      ini0 = 1'b0;
      n_cmp++;
      if (ok1 !== 1'b1 || ok2 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %b%b want 11", ok1, ok2);
      end
      n_cmp++;
      if (at2 - at1 !== L1 + 1) begin
         n_fail++;
         $display("FAIL b2b_period: got %0d want %0d", at2 - at1, L1 + 1);
      end
      n_cmp++;
      if (last_hi_run[0] !== 1) begin
         n_fail++;
         $display("FAIL b2b_cs_gap: got %0d want 1", last_hi_run[0]);
      end
      e1 = stream_errs(0, base, pat);
      e2 = stream_errs(0, base + 1030, pat);
      n_cmp++;
      if (mcnt[0] - base !== 2060 || e1 !== 0 || e2 !== 0) begin
         n_fail++;
         $display("FAIL b2b_stream: got %0d bytes %0d/%0d bad want 2060 0/0", mcnt[0] - base, e1, e2);
      end
      repeat (30) @(negedge clk);
      n_cmp++;
      if (ocup[0] !== 1'b0 || csn[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_stop: got ocupado=%b cs_n=%b want 0 1", ocup[0], csn[0]);
      end
      n_cmp++;
      if (stab_err[0] !== 0) begin
         n_fail++;
         $display("FAIL div1_stability: got %0d violations want 0", stab_err[0]);
      end
   endtask

   task automatic test_divider();
      logic [8191:0] pat4;
      int base, at, e;
      bit ok;
      for (int i = 0; i < 1024; i++) pat4[i * 8 +: 8] = 8'(i * 7 + 3);
      img1 = pat4;
      base = mcnt[1];
      @(negedge clk); ini1 = 1'b1;
      @(posedge clk); #1; ini1 = 1'b0;
      n_cmp++;
      if ({ocup[1], csn[1], dc[1], sclk[1], mosi[1], qp[1]} !== 6'b100000) begin
         n_fail++;
         $display("FAIL div4_t1_outputs: got %b want 100000",
                  {ocup[1], csn[1], dc[1], sclk[1], mosi[1], qp[1]});
      end
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (sclk[1] !== 1'b0) begin n_fail++; $display("FAIL div4_sclk_t4: got %b want 0", sclk[1]); end
      @(posedge clk); #1;
      n_cmp++;
      if (sclk[1] !== 1'b1) begin n_fail++; $display("FAIL div4_sclk_t5: got %b want 1", sclk[1]); end
      wait_qp(1, 66000, ok, at);
      n_cmp++;
      if (ok !== 1'b1 || at - csfall_cyc[1] !== L4) begin
         n_fail++;
         $display("FAIL div4_length: got ok=%b len=%0d want 1 %0d", ok, at - csfall_cyc[1], L4);
      end
      n_cmp++;
      if (phase_err[1] !== 0) begin
         n_fail++;
         $display("FAIL div4_phases: got %0d bad phases want 0", phase_err[1]);
      end
      n_cmp++;
      if (stab_err[1] !== 0) begin
         n_fail++;
         $display("FAIL div4_stability: got %0d violations want 0", stab_err[1]);
      end
      e = stream_errs(1, base, pat4);
      n_cmp++;
      if (mcnt[1] - base !== 1030 || e !== 0) begin
         n_fail++;
         $display("FAIL div4_stream: got %0d bytes %0d bad want 1030 0", mcnt[1] - base, e);
      end
   endtask

   initial begin
      logic [8191:0] pat;
      for (int i = 0; i < 1024; i++) pat[i * 8 +: 8] = 8'(i) ^ 8'h5A;
      rst0 = 1'b1; rst1 = 1'b1;
      ini0 = 1'b0; ini1 = 1'b0;
      img0 = '0;   img1 = '0;
      test_reset();
      fork
         begin
            test_single_frame();
            test_reset_mid(pat);
            test_back_to_back(pat);
         end
         begin
            test_divider();
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
